// File: rtl/if_id_stage_if.sv
// Fetch/decode boundary bundle: instruction-memory handshake, pipeline control, ID register outputs.
// master = fetch stage; slave = memory/decoder environment.
interface if_id_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [2:0]  id_immsel;
  logic        id_illegal;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_instr, id_immsel, id_illegal,
    input  imem_ack, imem_rdata, stall, flush, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_instr, id_immsel, id_illegal,
    output imem_ack, imem_rdata, stall, flush, redirect_pc
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID stage: fetches words from imem into the ID register with immediate-format pre-decode; ack->ID is 1 cycle.
// Backpressure: stall parks one acked word in a skid entry and drops imem_req until decode accepts it.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n,
  if_id_stage_if.master bus
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state, stateN;
  logic        started;
  logic [31:0] pc, pcN;
  logic [31:0] drainAddr, drainAddrN;
  logic [31:0] skidPc, skidPcN;
  logic [31:0] skidInstr, skidInstrN;
  logic        idValid, idValidN;
  logic [31:0] idPc, idPcN;
  logic [31:0] idInstr, idInstrN;
  logic [2:0]  idImmsel, idImmselN;
  logic        idIllegal, idIllegalN;

  logic        loadId;
  logic [31:0] loadPc, loadInstr;
  logic        ackHit;
  logic [31:0] redirAligned;

  // {illegal, immsel}
  function automatic logic [3:0] decodeOp(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0110011: decodeOp = 4'b0_000;
      7'b0100011:                                                 decodeOp = 4'b0_001;
      7'b1100011:                                                 decodeOp = 4'b0_010;
      7'b0110111, 7'b0010111:                                     decodeOp = 4'b0_011;
      7'b1101111:                                                 decodeOp = 4'b0_100;
      default:                                                    decodeOp = 4'b1_000;
    endcase
  endfunction

  // started keeps the request low until the first edge after reset release
  assign bus.imem_req   = started && (state != HOLD);
  assign bus.imem_addr  = (state == DRAIN) ? drainAddr : pc;
  assign bus.id_valid   = idValid;
  assign bus.id_pc      = idPc;
  assign bus.id_instr   = idInstr;
  assign bus.id_immsel  = idImmsel;
  assign bus.id_illegal = idIllegal;

  assign ackHit       = bus.imem_ack && bus.imem_req;
  assign redirAligned = bus.redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      started   <= 1'b0;
      pc        <= RESET_PC;
      drainAddr <= 32'h0;
      skidPc    <= 32'h0;
      skidInstr <= 32'h0000_0013;
      idValid   <= 1'b0;
      idPc      <= 32'h0;
      idInstr   <= 32'h0000_0013;
      idImmsel  <= 3'b000;
      idIllegal <= 1'b0;
    end else begin
      state     <= stateN;
      started   <= 1'b1;
      pc        <= pcN;
      drainAddr <= drainAddrN;
      skidPc    <= skidPcN;
      skidInstr <= skidInstrN;
      idValid   <= idValidN;
      idPc      <= idPcN;
      idInstr   <= idInstrN;
      idImmsel  <= idImmselN;
      idIllegal <= idIllegalN;
    end
  end

  always_comb begin
    stateN     = state;
    pcN        = pc;
    drainAddrN = drainAddr;
    skidPcN    = skidPc;
    skidInstrN = skidInstr;
    idValidN   = idValid;
    idPcN      = idPc;
    idInstrN   = idInstr;
    idImmselN  = idImmsel;
    idIllegalN = idIllegal;
    loadId     = 1'b0;
    loadPc     = skidPc;
    loadInstr  = skidInstr;

    case (state)
      FETCH: begin
        if (bus.flush) begin
          idValidN = 1'b0;
          pcN      = redirAligned;
          // an unacked request must still be retired before fetching the new target
          if (!ackHit && started) begin
            drainAddrN = pc;
            stateN     = DRAIN;
          end
        end else if (ackHit) begin
          pcN = pc + 32'd4;
          if (bus.stall) begin
            skidPcN    = pc;
            skidInstrN = bus.imem_rdata;
            stateN     = HOLD;
          end else begin
            loadId    = 1'b1;
            loadPc    = pc;
            loadInstr = bus.imem_rdata;
          end
        end else if (!bus.stall) begin
          idValidN = 1'b0;
        end
      end
      HOLD: begin
        if (bus.flush) begin
          idValidN = 1'b0;
          pcN      = redirAligned;
          stateN   = FETCH;
        end else if (!bus.stall) begin
          loadId = 1'b1;
          stateN = FETCH;
        end
      end
      DRAIN: begin
        if (bus.flush) begin
          idValidN = 1'b0;
          pcN      = redirAligned;
        end
        if (ackHit) begin
          stateN = FETCH;
        end
      end
      default: stateN = FETCH;
    endcase

    if (loadId) begin
      idValidN                = 1'b1;
      idPcN                   = loadPc;
      idInstrN                = loadInstr;
      {idIllegalN, idImmselN} = decodeOp(loadInstr[6:0]);
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: per-cycle stimulus table with expected outputs queued at drive time and
// popped after the clock edge, plus hand sequences for async reset and PC wrap.
module tb_if_id_stage;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  if_id_stage_if bus0 ();
  if_id_stage_if bus1 ();

  if_id_stage #(.RESET_PC(32'h0000_0000)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  imm;
    logic        ill;
  } exp_t;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] redir;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t sbq[$];

  function automatic vec_t mk(input logic st, input logic fl, input logic ak,
                              input logic [31:0] rd, input logic [31:0] rp,
                              input logic req, input logic [31:0] addr, input logic val,
                              input logic [31:0] pc, input logic [31:0] instr,
                              input logic [2:0] imm, input logic ill);
    vec_t r;
    r.stall   = st;
    r.flush   = fl;
    r.ack     = ak;
    r.rdata   = rd;
    r.redir   = rp;
    r.e.req   = req;
    r.e.addr  = addr;
    r.e.valid = val;
    r.e.pc    = pc;
    r.e.instr = instr;
    r.e.imm   = imm;
    r.e.ill   = ill;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus0.imem_ack = 1'b0; bus0.imem_rdata = 32'h0; bus0.stall = 1'b0; bus0.flush = 1'b0; bus0.redirect_pc = 32'h0;
    bus1.imem_ack = 1'b0; bus1.imem_rdata = 32'h0; bus1.stall = 1'b0; bus1.flush = 1'b0; bus1.redirect_pc = 32'h0;

    //          st fl ak rdata         redir         req addr          val pc            instr         imm    ill
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'h0,   1, 32'h0,   0, 32'h0,   32'h0,         3'd0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0050_0093, 32'h0,   1, 32'h4,   1, 32'h0,   32'h0050_0093, 3'd0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0010_2023, 32'h0,   1, 32'h8,   1, 32'h4,   32'h0010_2023, 3'd1, 0));
    vecs.push_back(mk(1, 0, 1, 32'hFE00_0EE3, 32'h0,   0, 32'h0,   1, 32'h4,   32'h0010_2023, 3'd1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,   0, 32'h0,   1, 32'h4,   32'h0010_2023, 3'd1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'h0,   1, 32'hC,   1, 32'h8,   32'hFE00_0EE3, 3'd2, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'h0,   1, 32'hC,   0, 32'h0,   32'h0,         3'd0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0013, 32'h0,   1, 32'h10,  1, 32'hC,   32'h0000_0013, 3'd0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         32'h100, 1, 32'h10,  0, 32'h0,   32'h0,         3'd0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'h0,   1, 32'h10,  0, 32'h0,   32'h0,         3'd0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h1234_5678, 32'h0,   1, 32'h100, 0, 32'h0,   32'h0,         3'd0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_006F, 32'h0,   1, 32'h104, 1, 32'h100, 32'h0000_006F, 3'd4, 0));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFF, 32'h0,   1, 32'h108, 1, 32'h104, 32'hFFFF_FFFF, 3'd0, 1));
    vecs.push_back(mk(0, 1, 1, 32'h0000_0013, 32'h203, 1, 32'h200, 0, 32'h0,   32'h0,         3'd0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0037, 32'h0,   1, 32'h204, 1, 32'h200, 32'h0000_0037, 3'd3, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0017, 32'h0,   1, 32'h208, 1, 32'h204, 32'h0000_0017, 3'd3, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,   1, 32'h208, 1, 32'h204, 32'h0000_0017, 3'd3, 0));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0067, 32'h0,   0, 32'h0,   1, 32'h204, 32'h0000_0017, 3'd3, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         32'h300, 1, 32'h300, 0, 32'h0,   32'h0,         3'd0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0033, 32'h0,   1, 32'h304, 1, 32'h300, 32'h0000_0033, 3'd0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         32'h400, 1, 32'h304, 0, 32'h0,   32'h0,         3'd0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         32'h500, 1, 32'h304, 0, 32'h0,   32'h0,         3'd0, 0));
    vecs.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 32'h0,   1, 32'h500, 0, 32'h0,   32'h0,         3'd0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0073, 32'h0,   1, 32'h504, 1, 32'h500, 32'h0000_0073, 3'd0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0003, 32'h0,   1, 32'h508, 1, 32'h504, 32'h0000_0003, 3'd0, 0));

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req",     0, {31'h0, bus0.imem_req},   32'h0);
    chk("rst_valid",   0, {31'h0, bus0.id_valid},   32'h0);
    chk("rst_pc",      0, bus0.id_pc,               32'h0);
    chk("rst_instr",   0, bus0.id_instr,            32'h0000_0013);
    chk("rst_immsel",  0, {29'h0, bus0.id_immsel},  32'h0);
    chk("rst_illegal", 0, {31'h0, bus0.id_illegal}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("req_before_first_edge", 0, {31'h0, bus0.imem_req}, 32'h0);

    foreach (vecs[i]) begin
      bus0.stall       = vecs[i].stall;
      bus0.flush       = vecs[i].flush;
      bus0.imem_ack    = vecs[i].ack;
      bus0.imem_rdata  = vecs[i].rdata;
      bus0.redirect_pc = vecs[i].redir;
      sbq.push_back(vecs[i].e);
      @(posedge clk);
      @(negedge clk);
      e = sbq.pop_front();
      chk("imem_req", i, {31'h0, bus0.imem_req}, {31'h0, e.req});
      if (e.req) chk("imem_addr", i, bus0.imem_addr, e.addr);
      chk("id_valid", i, {31'h0, bus0.id_valid}, {31'h0, e.valid});
      if (e.valid) begin
        chk("id_pc",      i, bus0.id_pc,               e.pc);
        chk("id_instr",   i, bus0.id_instr,            e.instr);
        chk("id_immsel",  i, {29'h0, bus0.id_immsel},  {29'h0, e.imm});
        chk("id_illegal", i, {31'h0, bus0.id_illegal}, {31'h0, e.ill});
      end
    end

    // reset asserted mid-transaction takes effect without a clock edge
    bus0.imem_ack = 1'b0;
    bus0.stall    = 1'b0;
    bus0.flush    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req",   100, {31'h0, bus0.imem_req}, 32'h0);
    chk("async_rst_valid", 100, {31'h0, bus0.id_valid}, 32'h0);
    chk("async_rst_pc",    100, bus0.id_pc,             32'h0);
    chk("async_rst_instr", 100, bus0.id_instr,          32'h0000_0013);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("restart_req",  101, {31'h0, bus0.imem_req}, 32'h1);
    chk("restart_addr", 101, bus0.imem_addr,         32'h0);
    chk("wrap_first_addr", 102, bus1.imem_addr,      32'hFFFF_FFFC);

    // pc wrap from the top of the address space
    bus1.imem_ack   = 1'b1;
    bus1.imem_rdata = 32'h0000_0013;
    @(posedge clk);
    @(negedge clk);
    bus1.imem_ack = 1'b0;
    chk("wrap_next_addr", 103, bus1.imem_addr,         32'h0);
    chk("wrap_valid",     103, {31'h0, bus1.id_valid}, 32'h1);
    chk("wrap_id_pc",     103, bus1.id_pc,             32'hFFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
